// File: rtl/adpll_pkg.sv
// Shared ADPLL types and widths: TDC code width, count/error widths and the
// phase-detector decoder FSM states.
package adpll_pkg;

  localparam int TDC_BITS = 32;
  localparam int CNT_W    = 6;
  localparam int ERR_W    = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    EMIT     = 2'd2,
    WAIT_CLR = 2'd3
  } tdc_state_e;

endpackage

// File: rtl/therm_popcount.sv
// Combinational thermometer-code decoder: ones count plus a bubble flag for
// any code that is not a contiguous run of ones from bit 0.
module therm_popcount
  import adpll_pkg::*;
#(
  parameter int TDC_BITS = adpll_pkg::TDC_BITS
) (
  input  logic [TDC_BITS-1:0] i_code,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_bubble
);

  logic [CNT_W-1:0]    w_sum;
  logic [TDC_BITS-1:0] w_plus_one;

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    w_sum = '0;
    for (int i = 0; i < TDC_BITS; i++) begin
      w_sum = w_sum + CNT_W'(i_code[i]);
    end
  end

  // A clean code 0..01..1 plus one is a power of two (or wraps to zero for
  // all ones), so it shares no set bit with the code itself.
  assign w_plus_one = i_code + TDC_BITS'(1);
  assign o_bubble   = |(i_code & w_plus_one);
  assign o_count    = w_sum;

endmodule

// File: rtl/tdc_therm_decoder.sv
// Thermometer TDC consumer: synchronises UP/DWN codes, tracks each detection
// event to its peak counts and emits one signed phase-error word per event.
module tdc_therm_decoder
  import adpll_pkg::*;
#(
  parameter int TDC_BITS    = adpll_pkg::TDC_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ACTIVE  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TDC_BITS-1:0] up_error,
  input  logic [TDC_BITS-1:0] dwn_error,
  output logic [ERR_W-1:0]    phase_err,
  output logic                err_valid,
  output logic                overflow,
  output logic                code_err
);

  localparam int TMR_W = $clog2(MAX_ACTIVE + 1);

  logic [TDC_BITS-1:0] r_up_sync  [SYNC_STAGES];
  logic [TDC_BITS-1:0] r_dwn_sync [SYNC_STAGES];
  logic [CNT_W-1:0]    r_cnt_up, r_cnt_dwn;
  logic                r_bub_up, r_bub_dwn;
  logic [CNT_W-1:0]    w_cnt_up, w_cnt_dwn;
  logic                w_bub_up, w_bub_dwn;

  tdc_state_e          r_state;
  logic [CNT_W-1:0]    r_peak_up, r_peak_dwn;
  logic [TMR_W-1:0]    r_timer;
  logic                r_bubble, r_timeout;
  logic [ERR_W-1:0]    r_phase_err;
  logic                r_err_valid, r_overflow, r_code_err;

  // Codes can clear asynchronously, so every bit is resynchronised first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the sync chain is a handful of flops, not a RAM, so it is reset
      // like any other state to give a defined count after reset.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_up_sync[i]  <= '0;
        r_dwn_sync[i] <= '0;
      end
      r_cnt_up  <= '0;
      r_cnt_dwn <= '0;
      r_bub_up  <= 1'b0;
      r_bub_dwn <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
      r_up_sync[0]  <= up_error;
      r_dwn_sync[0] <= dwn_error;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_up_sync[i]  <= r_up_sync[i-1];
        r_dwn_sync[i] <= r_dwn_sync[i-1];
      end
      r_cnt_up  <= w_cnt_up;
      r_cnt_dwn <= w_cnt_dwn;
      r_bub_up  <= w_bub_up;
      r_bub_dwn <= w_bub_dwn;
    end
  end

  therm_popcount #(.TDC_BITS(TDC_BITS)) u_pop_up (
    .i_code   (r_up_sync[SYNC_STAGES-1]),
    .o_count  (w_cnt_up),
    .o_bubble (w_bub_up)
  );

  therm_popcount #(.TDC_BITS(TDC_BITS)) u_pop_dwn (
    .i_code   (r_dwn_sync[SYNC_STAGES-1]),
    .o_count  (w_cnt_dwn),
    .o_bubble (w_bub_dwn)
  );

  logic             w_any, w_bub_now, w_timeout;
  logic [CNT_W-1:0] w_peak_up_nxt, w_peak_dwn_nxt;
  logic [ERR_W-1:0] w_diff;

  assign w_any          = (r_cnt_up != '0) || (r_cnt_dwn != '0);
  assign w_bub_now      = r_bub_up | r_bub_dwn;
  assign w_timeout      = (r_timer == TMR_W'(MAX_ACTIVE - 1));
  assign w_peak_up_nxt  = (r_cnt_up  > r_peak_up)  ? r_cnt_up  : r_peak_up;
  assign w_peak_dwn_nxt = (r_cnt_dwn > r_peak_dwn) ? r_cnt_dwn : r_peak_dwn;
  // Zero-extended 6-bit operands in 7 bits: the difference always fits.
  assign w_diff         = {1'b0, w_peak_up_nxt} - {1'b0, w_peak_dwn_nxt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_peak_up   <= '0;
      r_peak_dwn  <= '0;
      r_timer     <= '0;
      r_bubble    <= 1'b0;
      r_timeout   <= 1'b0;
      r_phase_err <= '0;
      r_err_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_code_err  <= 1'b0;
    end else begin
      r_err_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_code_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_peak_up  <= r_cnt_up;
            r_peak_dwn <= r_cnt_dwn;
            r_bubble   <= w_bub_now;
            r_timer    <= '0;
            r_state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          r_peak_up  <= w_peak_up_nxt;
          r_peak_dwn <= w_peak_dwn_nxt;
          r_bubble   <= r_bubble | w_bub_now;
          r_timer    <= r_timer + TMR_W'(1);
          // A normal close wins if it coincides with the timer expiring.
          if (!w_any || w_timeout) begin
            r_phase_err <= w_diff;
            r_err_valid <= 1'b1;
            r_overflow  <= w_any;
            r_code_err  <= r_bubble | w_bub_now;
            r_timeout   <= w_any;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          r_timeout  <= 1'b0;
          r_peak_up  <= '0;
          r_peak_dwn <= '0;
          r_timer    <= '0;
          r_bubble   <= 1'b0;
          if (r_timeout && w_any) begin
            r_state <= WAIT_CLR;
          end else if (w_any) begin
            r_peak_up  <= r_cnt_up;
            r_peak_dwn <= r_cnt_dwn;
            r_bubble   <= w_bub_now;
            r_state    <= ACTIVE;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_CLR: begin
          if (!w_any) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign phase_err = r_phase_err;
  assign err_valid = r_err_valid;
  assign overflow  = r_overflow;
  assign code_err  = r_code_err;

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Scoreboard bench for tdc_therm_decoder: directed events push expected
// strobes; a monitor pops and compares on every err_valid.
module tb_tdc_therm_decoder;

  logic        clk;
  logic        reset;
  logic [31:0] up_error, dwn_error;
  logic [6:0]  phase_err;
  logic        err_valid, overflow, code_err;

  typedef struct {
    logic [6:0] phase;
    logic       ovf;
    logic       cerr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  tdc_therm_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .up_error  (up_error),
    .dwn_error (dwn_error),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .overflow  (overflow),
    .code_err  (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [31:0] up, input logic [31:0] dwn, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      up_error  = up;
      dwn_error = dwn;
    end
  endtask

  task automatic push(input logic [6:0] phase, input logic ovf, input logic cerr);
    exp_t e;
    e.phase = phase;
    e.ovf   = ovf;
    e.cerr  = cerr;
    sb_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!err_valid && (overflow || code_err))
        check("stray_flag", {30'd0, overflow, code_err}, 32'd0);
      if (err_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", {31'd0, err_valid}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("phase_err", {25'd0, phase_err}, {25'd0, e.phase});
          check("overflow",  {31'd0, overflow},  {31'd0, e.ovf});
          check("code_err",  {31'd0, code_err},  {31'd0, e.cerr});
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    up_error  = '0;
    dwn_error = '0;
    #3;
    check("rst_phase", {25'd0, phase_err}, 32'd0);
    check("rst_valid", {31'd0, err_valid}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    check("rst_cerr",  {31'd0, code_err},  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive('0, '0, 4);

    // Pure UP ramp to eight ones
    push(7'd8, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) drive((32'd1 << i) - 32'd1, '0, 1);
    drive('0, '0, 10);

    // Mixed: UP 12, DWN 5
    push(7'd7, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++)
      drive((32'd1 << i) - 32'd1, (32'd1 << ((i < 5) ? i : 5)) - 32'd1, 1);
    drive('0, '0, 10);

    // Mirror: UP 5, DWN 12 -> -7
    push(7'h79, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++)
      drive((32'd1 << ((i < 5) ? i : 5)) - 32'd1, (32'd1 << i) - 32'd1, 1);
    drive('0, '0, 10);

    // Bubble code
    push(7'd7, 1'b0, 1'b1);
    drive(32'h0000_00F7, '0, 2);
    drive('0, '0, 10);

    // Stuck code: one timeout strobe, none after while held
    push(7'd32, 1'b1, 1'b0);
    drive(32'hFFFF_FFFF, '0, 600);
    drive('0, '0, 10);

    // Back-to-back events separated by a single zero cycle
    push(7'd3, 1'b0, 1'b0);
    push(7'd9, 1'b0, 1'b0);
    drive(32'h0000_0007, '0, 1);
    drive('0, '0, 1);
    drive(32'h0000_01FF, '0, 1);
    drive('0, '0, 10);

    // Reset in the middle of an event: no strobe, outputs cleared at once
    drive(32'h0000_000F, '0, 8);
    @(negedge clk);
    reset     = 1'b1;
    up_error  = '0;
    dwn_error = '0;
    #1;
    check("midrst_phase", {25'd0, phase_err}, 32'd0);
    check("midrst_valid", {31'd0, err_valid}, 32'd0);
    check("midrst_ovf",   {31'd0, overflow},  32'd0);
    check("midrst_cerr",  {31'd0, code_err},  32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive('0, '0, 6);

    // Next event after reset decodes normally
    push(7'd6, 1'b0, 1'b0);
    drive(32'h0000_003F, '0, 3);
    drive('0, '0, 20);

    check("sb_drained", sb_q.size(), 32'd0);
    check("phase_hold", {25'd0, phase_err}, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
